mem_arbiter: RTL and testbench

//  Shares the single 8-bit memory port between two requesters: port 0 (cpu fetch/load)
//  and port 1 (program loader / debug). Sits between them and memory; sequences each

---
 rtl/mem_pkg.sv | 17 +
 rtl/rr_arb2.sv | 22 ++
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the two-port memory arbiter: memory operation codes,
// the transaction sequencer state encoding and default bus widths.
package mem_pkg;

    localparam int DEFAULT_ADDR_W = 8;
    localparam int DEFAULT_DATA_W = 8;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. When both ports ask at once, the port that did
// not win last time gets the grant, so neither requester can starve the other.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic winner
);

    // A lone requester always wins; a tie goes to the port opposite last_grant.
    always_comb begin
        valid  = req0 | req1;
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last_grant;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between requester 0 (cpu) and requester 1 (loader /
// debug). Each access is sequenced as: grant and drive the memory bus, wait
// MEM_LATENCY edges, capture read data and pulse the requester's ack, then
// spend one cycle in DONE so the requester can drop its request.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    input  logic [DATA_W-1:0] from_memory,
    output logic              memory_operation,
    output logic [ADDR_W-1:0] memory_address,
    output logic [DATA_W-1:0] to_memory
);

    localparam int              CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    state_t           state;
    logic             grant;
    logic             last_grant;
    logic [CNT_W-1:0] cnt;
    logic             arb_valid;
    logic             arb_winner;

    rr_arb2 u_rr_arb2 (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant),
        .valid      (arb_valid),
        .winner     (arb_winner)
    );

    // Transaction sequencer: the request inputs are only looked at in IDLE, so
    // anything the requesters do mid-access cannot disturb the one in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            grant            <= 1'b0;
            last_grant       <= 1'b1;
            cnt              <= '0;
            ack0             <= 1'b0;
            ack1             <= 1'b0;
            rdata0           <= '0;
            rdata1           <= '0;
            memory_operation <= MEM_READ;
            memory_address   <= '0;
            to_memory        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant      <= arb_winner;
                        last_grant <= arb_winner;
                        cnt        <= CNT_LOAD;
                        state      <= WAIT;
                        if (arb_winner) begin
                            memory_address   <= addr1;
                            memory_operation <= we1;
                            to_memory        <= wdata1;
                        end else begin
                            memory_address   <= addr0;
                            memory_operation <= we0;
                            to_memory        <= wdata0;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_LAST) begin
                        if (memory_operation == MEM_READ) begin
                            if (grant) begin
                                rdata1 <= from_memory;
                            end else begin
                                rdata0 <= from_memory;
                            end
                        end
                        if (grant) begin
                            ack1 <= 1'b1;
                        end else begin
                            ack0 <= 1'b1;
                        end
                        memory_operation <= MEM_READ;
                        state            <= DONE;
                    end
                end
                DONE: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. Two copies of the arbiter are exercised one after the
// other: index 0 with a memory latency of 1 and index 1 with a latency of 3.
// Each copy gets its own behavioural memory whose read data appears exactly
// MEM_LATENCY edges after the address is driven.
module tb_mem_arbiter;

    typedef struct packed {
        logic       port;
        logic [7:0] rdata;
    } txn_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      req0, req1, we0, we1;
    logic [1:0][7:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]      ack0, ack1, mop;
    logic [1:0][7:0] rdata0, rdata1, maddr, tomem, from_memory;

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic [7:0] p1a, p1b;

    txn_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(reset),
        .req0(req0[0]), .req1(req1[0]), .we0(we0[0]), .we1(we1[0]),
        .addr0(addr0[0]), .addr1(addr1[0]), .wdata0(wdata0[0]), .wdata1(wdata1[0]),
        .ack0(ack0[0]), .ack1(ack1[0]), .rdata0(rdata0[0]), .rdata1(rdata1[0]),
        .from_memory(from_memory[0]), .memory_operation(mop[0]),
        .memory_address(maddr[0]), .to_memory(tomem[0])
    );

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LATENCY(3)) u_dut_l3 (
        .clk(clk), .reset(reset),
        .req0(req0[1]), .req1(req1[1]), .we0(we0[1]), .we1(we1[1]),
        .addr0(addr0[1]), .addr1(addr1[1]), .wdata0(wdata0[1]), .wdata1(wdata1[1]),
        .ack0(ack0[1]), .ack1(ack1[1]), .rdata0(rdata0[1]), .rdata1(rdata1[1]),
        .from_memory(from_memory[1]), .memory_operation(mop[1]),
        .memory_address(maddr[1]), .to_memory(tomem[1])
    );

    // Power-on memory contents: 0x10 holds 0xA5, every other byte is addr^0x5A.
    function automatic logic [7:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 8'hA5 : (a ^ 8'h5A);
    endfunction

    function automatic logic [7:0] read_mem(input int i, input logic [7:0] a);
        return (i == 0) ? mem0[a] : mem1[a];
    endfunction

    // Latency-1 memory: reloaded while reset is high, written while the strobe is high.
    always @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < 256; a++) mem0[a] <= init_val(8'(a));
        end else if (mop[0]) begin
            mem0[maddr[0]] <= tomem[0];
        end
    end

    // Latency-3 memory: same storage behaviour plus a two-stage read pipeline.
    always @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < 256; a++) mem1[a] <= init_val(8'(a));
        end else if (mop[1]) begin
            mem1[maddr[1]] <= tomem[1];
        end
        p1a <= mem1[maddr[1]];
        p1b <= p1a;
    end

    assign from_memory[0] = mem0[maddr[0]];
    assign from_memory[1] = p1b;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearInputs();
        req0 = '0; req1 = '0; we0 = '0; we1 = '0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    // Drive one requester of copy i and optionally queue its expected completion.
    task automatic applyStimulus(input int i, input logic port, input logic we,
                                 input logic [7:0] addr, input logic [7:0] wdata,
                                 input logic [7:0] rdata_exp, input bit push);
        txn_t t;
        if (port) begin
            req1[i] = 1'b1; we1[i] = we; addr1[i] = addr; wdata1[i] = wdata;
        end else begin
            req0[i] = 1'b1; we0[i] = we; addr0[i] = addr; wdata0[i] = wdata;
        end
        if (push) begin
            t.port  = port;
            t.rdata = rdata_exp;
            sb.push_back(t);
        end
    endtask

    // Wait (bounded) for the next ack of copy i and compare it with the scoreboard.
    task automatic checkOutput(input int i, input int exp_gap, input bit drop, output int strobe);
        int   n    = 0;
        bit   seen = 1'b0;
        txn_t exp;
        strobe = 0;
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            if (mop[i]) strobe++;
            seen = ack0[i] | ack1[i];
        end
        check("ack_seen", 64'(seen), 64'd1);
        if (seen) begin
            check("ack_exclusive", 64'(ack0[i] & ack1[i]), 64'd0);
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check("ack_port", 64'(ack1[i]), 64'(exp.port));
                check("rdata", 64'(exp.port ? rdata1[i] : rdata0[i]), 64'(exp.rdata));
                check("ack_gap", 64'(n), 64'(exp_gap));
                if (drop) begin
                    if (exp.port) req1[i] = 1'b0; else req0[i] = 1'b0;
                end
                @(negedge clk);
                check("ack_pulse", 64'({ack0[i], ack1[i]}), 64'd0);
                check("rdata_held", 64'(exp.port ? rdata1[i] : rdata0[i]), 64'(exp.rdata));
            end
        end
    endtask

    task automatic runSuite(input int i);
        int lat;
        int s;
        lat = (i == 0) ? 1 : 3;

        // Reset state
        reset = 1'b1;
        clearInputs();
        repeat (3) @(negedge clk);
        check("rst_ctl", 64'({ack0[i], ack1[i], mop[i]}), 64'd0);
        check("rst_data", 64'({rdata0[i], rdata1[i], maddr[i], tomem[i]}), 64'd0);
        reset = 1'b0;

        // Port-0 read of a preloaded location
        applyStimulus(i, 1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b1);
        checkOutput(i, lat + 1, 1'b1, s);
        check("t1_addr", 64'(maddr[i]), 64'h10);
        check("t1_op", 64'(mop[i]), 64'd0);

        // Port-1 write: strobe width, bus values, memory contents, rdata1 untouched
        applyStimulus(i, 1'b1, 1'b1, 8'h20, 8'h3C, 8'h00, 1'b1);
        checkOutput(i, lat + 1, 1'b1, s);
        check("t2_strobe", 64'(s), 64'(lat));
        check("t2_addr", 64'(maddr[i]), 64'h20);
        check("t2_wdata", 64'(tomem[i]), 64'h3C);
        check("t2_mem", 64'(read_mem(i, 8'h20)), 64'h3C);
        we1[i] = 1'b0;

        // Read back the written byte through port 0
        applyStimulus(i, 1'b0, 1'b0, 8'h20, 8'h00, 8'h3C, 1'b1);
        checkOutput(i, lat + 1, 1'b1, s);

        // Port 0 drops req and scrambles addr mid-access while port 1 asks
        applyStimulus(i, 1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b1);
        @(negedge clk);
        req0[i]  = 1'b0;
        addr0[i] = 8'hFF;
        applyStimulus(i, 1'b1, 1'b0, 8'h30, 8'h00, 8'h6A, 1'b1);
        checkOutput(i, lat, 1'b1, s);
        checkOutput(i, lat + 1, 1'b1, s);

        // Both requests held from reset: grants alternate 0,1,0,1
        reset = 1'b1;
        clearInputs();
        applyStimulus(i, 1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b1);
        applyStimulus(i, 1'b1, 1'b0, 8'h30, 8'h00, 8'h6A, 1'b1);
        applyStimulus(i, 1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b1);
        applyStimulus(i, 1'b1, 1'b0, 8'h30, 8'h00, 8'h6A, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) checkOutput(i, lat + 1, k == 3, s);
        req0[i] = 1'b0;
        repeat (lat + 3) @(negedge clk);
        check("t3_idle", 64'({ack0[i], ack1[i], mop[i]}), 64'd0);

        // Reset during a write: strobe drops at once, no ack, port 0 wins afterwards
        applyStimulus(i, 1'b1, 1'b1, 8'h40, 8'h77, 8'h00, 1'b0);
        @(negedge clk);
        check("t5_op_before", 64'(mop[i]), 64'd1);
        reset = 1'b1;
        #1;
        check("t5_op_abort", 64'(mop[i]), 64'd0);
        check("t5_no_ack", 64'({ack0[i], ack1[i]}), 64'd0);
        applyStimulus(i, 1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b1);
        applyStimulus(i, 1'b1, 1'b0, 8'h30, 8'h00, 8'h6A, 1'b1);
        repeat (2) @(negedge clk);
        check("t5_no_ack_rst", 64'({ack0[i], ack1[i]}), 64'd0);
        reset = 1'b0;
        checkOutput(i, lat + 1, 1'b1, s);
        checkOutput(i, lat + 1, 1'b1, s);
        clearInputs();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        clearInputs();
        $display("[TB] latency-1 arbiter");
        runSuite(0);
        $display("[TB] latency-3 arbiter");
        runSuite(1);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
